// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: decodes the held IR and sequences FETCH/DECODE/EXECUTE/MEM/WB.
// Optional feature macro CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap into a sticky HALT state.
module multicycle_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic [3:0]  alu_op,
  output logic        sel_a,
  output logic        sel_b,
  output logic [2:0]  imm_sel,
  output logic        ir_en,
  output logic        pc_en,
  output logic        pc_sel,
  output logic        reg_wr,
  output logic [1:0]  wb_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        illegal_instr,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'b000,
    S_DECODE  = 3'b001,
    S_EXECUTE = 3'b010,
    S_MEM     = 3'b011,
    S_WB      = 3'b100,
    S_HALT    = 3'b101
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SRL  = 4'b0011;
  localparam logic [3:0] ALU_SRA  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_PASS = 4'b1010;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  state_t      state;
  state_t      state_next;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt;
  logic        is_load;
  logic        is_store;
  logic        is_jump;
  logic        unused_fields;

  assign opcode   = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign alt      = instruction[30];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_jump  = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign unused_fields = ^{instruction[31], instruction[29:15], instruction[11:7]};
  assign state_o  = state;

  // alt selects sub/sra; callers pre-qualify it for I-type so addi never becomes sub
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt_sel);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt_sel ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt_sel ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic known;
  assign known = (opcode == OP_R)     || (opcode == OP_IMM)    || (opcode == OP_LUI)  ||
                 (opcode == OP_AUIPC) || (opcode == OP_LOAD)   || (opcode == OP_STORE) ||
                 (opcode == OP_BRANCH)|| (opcode == OP_JAL)    || (opcode == OP_JALR);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode; rst forces every output low combinationally
  always_comb begin
    state_next    = state;
    alu_op        = ALU_ADD;
    sel_a         = 1'b0;
    sel_b         = 1'b0;
    imm_sel       = IMM_I;
    ir_en         = 1'b0;
    pc_en         = 1'b0;
    pc_sel        = 1'b0;
    reg_wr        = 1'b0;
    wb_sel        = 2'b00;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    illegal_instr = 1'b0;
    if (rst) begin
      state_next = S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          ir_en      = 1'b1;
          state_next = S_DECODE;
        end
        S_DECODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_next = known ? S_EXECUTE : S_HALT;
`else
          state_next = S_EXECUTE;
`endif
        end
        S_EXECUTE: begin
          state_next = S_WB;
          case (opcode)
            OP_R: begin
              alu_op = alu_from_funct3(funct3, alt);
            end
            OP_IMM: begin
              sel_b  = 1'b1;
              alu_op = alu_from_funct3(funct3, alt && (funct3 == 3'b101));
            end
            OP_LUI: begin
              alu_op  = ALU_PASS;
              sel_b   = 1'b1;
              imm_sel = IMM_U;
            end
            OP_AUIPC: begin
              sel_a   = 1'b1;
              sel_b   = 1'b1;
              imm_sel = IMM_U;
            end
            OP_LOAD: begin
              sel_b      = 1'b1;
              state_next = S_MEM;
            end
            OP_STORE: begin
              sel_b      = 1'b1;
              imm_sel    = IMM_S;
              state_next = S_MEM;
            end
            OP_BRANCH: begin
              sel_a      = 1'b1;
              sel_b      = 1'b1;
              imm_sel    = IMM_B;
              pc_en      = 1'b1;
              pc_sel     = br_taken;
              state_next = S_FETCH;
            end
            OP_JAL: begin
              sel_a   = 1'b1;
              sel_b   = 1'b1;
              imm_sel = IMM_J;
            end
            OP_JALR: begin
              sel_b = 1'b1;
            end
            default: begin
              // Unknown opcode retires as a NOP (only reachable without the trap)
              pc_en      = 1'b1;
              state_next = S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = is_store;
          if (mem_ready) begin
            pc_en      = is_store;
            state_next = is_store ? S_FETCH : S_WB;
          end else begin
            state_next = S_MEM;
          end
        end
        S_WB: begin
          reg_wr     = 1'b1;
          pc_en      = 1'b1;
          pc_sel     = is_jump;
          wb_sel     = is_load ? 2'b01 : (is_jump ? 2'b10 : 2'b00);
          state_next = S_FETCH;
        end
        S_HALT: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          illegal_instr = 1'b1;
          state_next    = S_HALT;
`else
          state_next    = S_FETCH;
`endif
        end
        default: begin
          state_next = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; outputs are compared as one packed
// vector {state,alu_op,sel_a,sel_b,imm_sel,ir_en,pc_en,pc_sel,reg_wr,wb_sel,mem_req,mem_we,illegal}.
module tb_multicycle_controller;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        br_taken;
  logic        mem_ready;
  logic [3:0]  alu_op;
  logic        sel_a;
  logic        sel_b;
  logic [2:0]  imm_sel;
  logic        ir_en;
  logic        pc_en;
  logic        pc_sel;
  logic        reg_wr;
  logic [1:0]  wb_sel;
  logic        mem_req;
  logic        mem_we;
  logic        illegal_instr;
  logic [2:0]  state_o;
  logic [20:0] outs;

  int checks;
  int failures;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .instruction(instruction), .br_taken(br_taken),
    .mem_ready(mem_ready), .alu_op(alu_op), .sel_a(sel_a), .sel_b(sel_b),
    .imm_sel(imm_sel), .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel),
    .reg_wr(reg_wr), .wb_sel(wb_sel), .mem_req(mem_req), .mem_we(mem_we),
    .illegal_instr(illegal_instr), .state_o(state_o)
  );

  assign outs = {state_o, alu_op, sel_a, sel_b, imm_sel, ir_en, pc_en, pc_sel,
                 reg_wr, wb_sel, mem_req, mem_we, illegal_instr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] pk(input logic [2:0] st, input logic [3:0] alu,
                                     input logic sa, input logic sb, input logic [2:0] imm,
                                     input logic ir, input logic pc, input logic ps,
                                     input logic rw, input logic [1:0] wb, input logic rq,
                                     input logic we, input logic il);
    return {st, alu, sa, sb, imm, ir, pc, ps, rw, wb, rq, we, il};
  endfunction

  localparam logic [20:0] EXP_ZERO = 21'd0;
  localparam logic [20:0] EXP_F  = {3'd0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] EXP_D  = {3'd1, 18'd0};
  localparam logic [20:0] EXP_WB = {3'd4, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_initial();
    rst = 1'b1;
    tick();
    checks++;
    if (outs !== EXP_ZERO) begin
      failures++;
      $display("FAIL reset_hold: got %h want %h", outs, EXP_ZERO);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== EXP_F) begin
      failures++;
      $display("FAIL reset_release: got %h want %h", outs, EXP_F);
    end
  endtask

  task automatic test_alu();
    logic [31:0] ins [0:13];
    logic [3:0]  alu [0:13];
    logic        sb  [0:13];
    logic [20:0] exp_v [0:3];
    ins = '{32'h002081B3, 32'h402081B3, 32'h002091B3, 32'h0020A1B3, 32'h0020B1B3,
            32'h0020C1B3, 32'h0020D1B3, 32'h4020D1B3, 32'h0020E1B3, 32'h0020F1B3,
            32'h4030D093, 32'h40008093, 32'h00109093, 32'h0FF0F093};
    alu = '{4'b0000, 4'b0001, 4'b0010, 4'b0101, 4'b0110, 4'b0111, 4'b0011, 4'b0100,
            4'b1000, 4'b1001, 4'b0100, 4'b0000, 4'b0010, 4'b1001};
    sb  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b1, 1'b1, 1'b1, 1'b1};
    for (int n = 0; n < 14; n++) begin
      instruction = ins[n];
      exp_v[0] = EXP_F;
      exp_v[1] = EXP_D;
      exp_v[2] = pk(3'd2, alu[n], 1'b0, sb[n], 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      exp_v[3] = EXP_WB;
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (outs !== exp_v[c]) begin
          failures++;
          $display("FAIL alu_%h cyc%0d: got %h want %h", ins[n], c, outs, exp_v[c]);
        end
        tick();
      end
    end
  endtask

  task automatic test_load_store();
    logic [20:0] exp_v [0:6];
    logic        rdy   [0:6];
    instruction = 32'h0080A283;
    exp_v = '{EXP_F, EXP_D,
              pk(3'd2, 4'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0),
              pk(3'd3, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0),
              pk(3'd3, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0),
              pk(3'd3, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0),
              pk(3'd4, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0)};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 7; c++) begin
      mem_ready = rdy[c];
      #1;
      checks++;
      if (outs !== exp_v[c]) begin
        failures++;
        $display("FAIL load cyc%0d: got %h want %h", c, outs, exp_v[c]);
      end
      tick();
    end
    mem_ready = 1'b0;
    instruction = 32'h0020A423;
    exp_v[2] = pk(3'd2, 4'd0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    exp_v[3] = pk(3'd3, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    exp_v[4] = EXP_F;
    for (int c = 0; c < 5; c++) begin
      mem_ready = (c == 3);
      #1;
      checks++;
      if (outs !== exp_v[c]) begin
        failures++;
        $display("FAIL store cyc%0d: got %h want %h", c, outs, exp_v[c]);
      end
      if (c < 4) tick();
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_branch();
    logic [20:0] exp_v [0:3];
    instruction = 32'h00208463;
    for (int t = 1; t >= 0; t--) begin
      br_taken = t[0];
      exp_v[0] = EXP_F;
      exp_v[1] = EXP_D;
      exp_v[2] = pk(3'd2, 4'd0, 1'b1, 1'b1, 3'b010, 1'b0, 1'b1, t[0], 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      exp_v[3] = EXP_F;
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (outs !== exp_v[c]) begin
          failures++;
          $display("FAIL branch_t%0d cyc%0d: got %h want %h", t, c, outs, exp_v[c]);
        end
        if (c < 3) tick();
      end
    end
    br_taken = 1'b0;
  endtask

  task automatic test_jump_upper();
    logic [31:0] ins [0:3];
    logic [20:0] ex  [0:3];
    logic [20:0] wb  [0:3];
    logic [20:0] exp_v [0:3];
    ins = '{32'h010000EF, 32'h000100E7, 32'h123452B7, 32'h00001297};
    ex  = '{pk(3'd2, 4'b0000, 1'b1, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0),
            pk(3'd2, 4'b0000, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0),
            pk(3'd2, 4'b1010, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0),
            pk(3'd2, 4'b0000, 1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0)};
    wb  = '{pk(3'd4, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0),
            pk(3'd4, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0),
            EXP_WB, EXP_WB};
    for (int n = 0; n < 4; n++) begin
      instruction = ins[n];
      exp_v = '{EXP_F, EXP_D, ex[n], wb[n]};
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (outs !== exp_v[c]) begin
          failures++;
          $display("FAIL jump_%h cyc%0d: got %h want %h", ins[n], c, outs, exp_v[c]);
        end
        tick();
      end
    end
  endtask

  task automatic test_reset_mid_load();
    instruction = 32'h0080A283;
    mem_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (state_o !== 3'd3) begin
      failures++;
      $display("FAIL rst_mid_reach_mem: got %0d want 3", state_o);
    end
    rst = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (outs !== EXP_ZERO) begin
        failures++;
        $display("FAIL rst_mid_hold cyc%0d: got %h want %h", c, outs, EXP_ZERO);
      end
      tick();
    end
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== EXP_F) begin
      failures++;
      $display("FAIL rst_mid_release: got %h want %h", outs, EXP_F);
    end
  endtask

  task automatic test_illegal();
    logic [20:0] exp_v [0:5];
    instruction = 32'h00000000;
`ifdef CTRL_ILLEGAL_TRAP_EN
    exp_v = '{EXP_F, EXP_D,
              pk(3'd5, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1),
              pk(3'd5, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1),
              pk(3'd5, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1),
              pk(3'd5, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1)};
`else
    exp_v = '{EXP_F, EXP_D,
              pk(3'd2, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0),
              EXP_F, EXP_D,
              pk(3'd2, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0)};
`endif
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (outs !== exp_v[c]) begin
        failures++;
        $display("FAIL illegal cyc%0d: got %h want %h", c, outs, exp_v[c]);
      end
      tick();
    end
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== EXP_ZERO) begin
      failures++;
      $display("FAIL illegal_rst: got %h want %h", outs, EXP_ZERO);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== EXP_F) begin
      failures++;
      $display("FAIL illegal_release: got %h want %h", outs, EXP_F);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    instruction = 32'h00000013;
    br_taken = 1'b0;
    mem_ready = 1'b0;
    test_reset_initial();
    test_alu();
    test_load_store();
    test_branch();
    test_jump_upper();
    test_reset_mid_load();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
